hs_skid_fifo: RTL and testbench
===============================

Name: hs_skid_fifo

Overview:
Parametrised valid/ready buffer for the handshake experiments. It decouples an upstream producer from a downstream consumer with DEPTH entries of DATA_W-bit storage. Both ready and valid outputs are registered, so there is no combinational path between the two sides. It also exposes a fill level, a wrapping count of completed output transfers, and a sticky flag for upstream protocol violations.

Parameters:
DATA_W, 8, payload width in bits (>=1)
DEPTH, 4, number of storage entries; power of two, >=2
CNT_W, 8, width of the transfer counter xfer_cnt

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  synchronous, active-high reset
s_valid  input  1  upstream presents data
s_data  input  DATA_W  upstream payload
s_ready  output  1  buffer can accept; registered
m_valid  output  1  buffer holds data for downstream; registered
m_data  output  DATA_W  payload at head of buffer
m_ready  input  1  downstream accepts
level  output  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH
xfer_cnt  output  CNT_W  number of completed output handshakes, mod 2^CNT_W
proto_err  output  1  sticky upstream protocol violation

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset, sampled on the clock edge, overrides everything in that cycle. After it: s_ready=1, m_valid=0, level=0, xfer_cnt=0, proto_err=0, pointers=0, m_data=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all stored entries. A handshake occurring in the reset cycle is not counted.
- Push occurs when s_valid & s_ready at a clock edge. Pop occurs when m_valid & m_ready at a clock edge.
- Latency: data pushed at edge N appears with m_valid=1 in the cycle after edge N, provided the buffer was empty.
- With m_ready held at 1 and s_valid held at 1, throughput is one beat per cycle.
- Order is strict FIFO. m_data is the head entry whenever m_valid=1, and is don't-care but stable when m_valid=0.
- s_ready = (level_next < DEPTH), registered. It depends only on internal state, never combinationally on m_ready.
- m_valid = (level_next > 0), registered.
- Simultaneous push and pop: level is unchanged, both pointers advance.
- Full (level=DEPTH): s_ready=0, so no push is possible. A pop in that cycle makes s_ready=1 in the next cycle.
- Empty (level=0): m_valid=0, so no pop is possible. A push in that cycle makes m_valid=1 in the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- level is a separate counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- xfer_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- proto_err is set to 1 and held until reset when, in cycle N, s_valid=1 and s_ready=0, and in cycle N+1 either:
  - s_valid=0 (valid withdrawn before acceptance), or
  - s_data differs from its value in cycle N.
- proto_err never blocks data flow.
- An m_ready change while m_valid=1 is legal for the consumer and is not flagged.

Decomposition:
- Shared package hs_pkg: constants HS_DATA_W_DEF=8, HS_DEPTH_DEF=4, HS_CNT_W_DEF=8, and a helper function for pointer width ($clog2 wrapper). No typedefs are required.
- One natural sub-module: hs_proto_chk, the upstream stability checker. Inputs: sys_clk, sys_rst, s_valid, s_ready, s_data. Output: proto_err. It holds a registered copy of the previous s_valid, s_ready and s_data. Storage and pointers stay in hs_skid_fifo.

Test Plan:
- Reset check: hold sys_rst=1 for 2 cycles with s_valid=1, s_data=8'hAA, then release. Required: during reset and the first cycle after it, s_ready=1, m_valid=0, level=0, xfer_cnt=0, proto_err=0; no entry is accepted during reset.
- Streaming: with m_ready=1, push 8'h01..8'h08 on consecutive cycles. Required: m_data=8'h01..8'h08 in order on consecutive cycles, starting one cycle after the first push; level stays at or below 1; xfer_cnt=8 at the end.
- Fill/backpressure: with m_ready=0, hold s_valid=1 and push 8'h10, 8'h11, ... Required: exactly 4 accepted, s_ready=0 with level=4 from the cycle after the 4th push. Then pulse m_ready for 1 cycle: m_data=8'h10 pops, s_ready=1 in the next cycle, and 8'h14 is accepted.
- Simultaneous push/pop at level=2 for 6 cycles: level stays 2, and output order matches input order across pointer wrap (pointer passes 3->0 at least once).
- Protocol violation: fill to full; drive s_valid=1, s_data=8'h55 while s_ready=0, then change to s_data=8'h56 next cycle. Required: proto_err=1 from the following cycle and it stays 1 while data continues to flow. A second case with s_valid dropped instead also sets proto_err; only a reset clears it.
- Counter wrap: with CNT_W=3, perform 9 pops. Required: xfer_cnt sequence 1..7, 0, 1. Then assert reset mid-stream with level=3: required level=0, m_valid=0 next cycle, and previous entries never appear on m_data.

Source files
------------

// File: rtl/hs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : hs_pkg                                                         |
// | Purpose : Shared defaults and helpers for the handshake buffer blocks.   |
// | Contents: HS_DATA_W_DEF, HS_DEPTH_DEF, HS_CNT_W_DEF, hs_ptr_w()          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package hs_pkg;

   localparam int HS_DATA_W_DEF = 8;
   localparam int HS_DEPTH_DEF  = 4;
   localparam int HS_CNT_W_DEF  = 8;

   // Width of a read/write pointer able to address DEPTH entries.
   function automatic int hs_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hs_proto_chk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hs_proto_chk                                                   |
// | Purpose : Sticky detector for upstream valid/ready protocol violations.  |
// |           Once a beat is offered but not accepted, the producer must     |
// |           keep s_valid high and s_data unchanged in the next cycle.      |
// | Ports   : sys_clk, sys_rst (sync, active-high)                           |
// |           s_valid, s_ready, s_data  - observed upstream interface        |
// |           proto_err                 - sticky violation flag              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hs_proto_chk #(
   parameter int DATA_W = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              s_valid,
   input  logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              proto_err
);

   logic              prev_valid_q, prev_valid_d;
   logic              prev_ready_q, prev_ready_d;
   logic [DATA_W-1:0] prev_data_q,  prev_data_d;
   logic              err_q,        err_d;

   always_comb begin
      prev_valid_d = s_valid;
      prev_ready_d = s_ready;
      prev_data_d  = s_data;
      err_d        = err_q;
      // A stalled offer last cycle must be repeated unchanged this cycle.
      if (prev_valid_q && !prev_ready_q) begin
         if (!s_valid || (s_data != prev_data_q)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         prev_valid_q <= 1'b0;
         prev_ready_q <= 1'b0;
         prev_data_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         prev_valid_q <= prev_valid_d;
         prev_ready_q <= prev_ready_d;
         prev_data_q  <= prev_data_d;
         err_q        <= err_d;
      end
   end

   assign proto_err = err_q;

endmodule
`default_nettype wire

// File: rtl/hs_skid_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hs_skid_fifo                                                   |
// | Purpose : DEPTH-entry valid/ready buffer with registered s_ready and     |
// |           m_valid, fill level, wrapping transfer counter and a sticky    |
// |           upstream protocol-violation flag.                              |
// | Ports   : sys_clk, sys_rst (sync, active-high)                           |
// |           s_valid/s_data/s_ready  - upstream (push) side                 |
// |           m_valid/m_data/m_ready  - downstream (pop) side                |
// |           level     - entries stored, 0..DEPTH                           |
// |           xfer_cnt  - completed output handshakes, mod 2^CNT_W           |
// |           proto_err - sticky upstream violation                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hs_skid_fifo
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W_DEF,
   parameter int DEPTH  = HS_DEPTH_DEF,
   parameter int CNT_W  = HS_CNT_W_DEF
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst,
   input  logic                         s_valid,
   input  logic [DATA_W-1:0]            s_data,
   output logic                         s_ready,
   output logic                         m_valid,
   output logic [DATA_W-1:0]            m_data,
   input  logic                         m_ready,
   output logic [$clog2(DEPTH):0]       level,
   output logic [CNT_W-1:0]             xfer_cnt,
   output logic                         proto_err
);

   localparam int PTR_W = hs_ptr_w(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
   logic [LVL_W-1:0]  level_q,    level_d;
   logic              s_ready_q,  s_ready_d;
   logic              m_valid_q,  m_valid_d;
   logic [DATA_W-1:0] m_data_q,   m_data_d;
   logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;

   logic push;
   logic pop;

   assign push = s_valid & s_ready_q;
   assign pop  = m_valid_q & m_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      xfer_cnt_d = xfer_cnt_q;
      m_data_d   = m_data_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      s_ready_d = (level_d < C_DEPTH);
      m_valid_d = (level_d != '0);

      // m_data is registered, so look ahead to next cycle's head. If the head
      // slot is the one being written this edge, the storage does not hold it
      // yet and the incoming beat is forwarded. When the buffer goes empty the
      // last value is simply held.
      if (m_valid_d) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            m_data_d = s_data;
         end else begin
            m_data_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         s_ready_q  <= 1'b1;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         xfer_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         s_ready_q  <= s_ready_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   // Storage carries no reset; entries are only meaningful between the
   // pointers, which are reset.
   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   hs_proto_chk #(
      .DATA_W (DATA_W)
   ) u_proto_chk (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready_q),
      .s_data    (s_data),
      .proto_err (proto_err)
   );

   assign s_ready  = s_ready_q;
   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign level    = level_q;
   assign xfer_cnt = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_skid_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_hs_skid_fifo                                                |
// | Purpose : Self-checking bench for hs_skid_fifo. A default-width instance |
// |           and a CNT_W=3 instance share the same stimulus; a queue        |
// |           scoreboard checks the output order of the default instance.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hs_skid_fifo;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       s_valid;
   logic [7:0] s_data;
   logic       m_ready;

   wire        s_ready, m_valid, proto_err;
   wire  [7:0] m_data;
   wire  [2:0] level;
   wire  [7:0] xfer_cnt;

   wire        s_ready3, m_valid3, proto_err3;
   wire  [7:0] m_data3;
   wire  [2:0] level3;
   wire  [2:0] xfer_cnt3;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q [$];
   logic [7:0] sb_exp;

   always #5 sys_clk = ~sys_clk;

   hs_skid_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) u_dut (
      .sys_clk (sys_clk), .sys_rst (sys_rst),
      .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
      .m_valid (m_valid), .m_data (m_data), .m_ready (m_ready),
      .level (level), .xfer_cnt (xfer_cnt), .proto_err (proto_err)
   );

   hs_skid_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(3)) u_dut3 (
      .sys_clk (sys_clk), .sys_rst (sys_rst),
      .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready3),
      .m_valid (m_valid3), .m_data (m_data3), .m_ready (m_ready),
      .level (level3), .xfer_cnt (xfer_cnt3), .proto_err (proto_err3)
   );

   // Scoreboard: inputs are driven just after posedge, so at negedge both
   // sides are stable and show exactly what the next edge will transfer.
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         exp_q.delete();
      end else begin
         if (m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL sb_pop: got m_data=%h with nothing pushed, required no pop", m_data);
            end else begin
               sb_exp = exp_q.pop_front();
               if (m_data !== sb_exp) begin
                  n_errors++;
                  $display("FAIL sb_order: got m_data=%h, required %h", m_data, sb_exp);
               end
            end
         end
         if (s_valid && s_ready) exp_q.push_back(s_data);
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA; m_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if ({s_ready, m_valid, level, xfer_cnt, proto_err} !== {1'b1, 1'b0, 3'd0, 8'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b lvl=%0d cnt=%0d err=%b, required 1 0 0 0 0",
                     s_ready, m_valid, level, xfer_cnt, proto_err);
         end
      end
      sys_rst = 1'b0; s_valid = 1'b0;
      tick();
      n_checks++;
      if ({s_ready, m_valid, level, xfer_cnt, proto_err} !== {1'b1, 1'b0, 3'd0, 8'd0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_after: got rdy=%b vld=%b lvl=%0d cnt=%0d err=%b, required 1 0 0 0 0",
                  s_ready, m_valid, level, xfer_cnt, proto_err);
      end
   endtask

   task automatic test_streaming();
      logic [7:0] v;
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         v = i[7:0];
         s_valid = 1'b1; s_data = v;
         tick();
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== v) begin
            n_errors++;
            $display("FAIL stream_data: got vld=%b data=%h, required 1 %h", m_valid, m_data, v);
         end
         n_checks++;
         if (level !== 3'd1) begin
            n_errors++;
            $display("FAIL stream_level: got %0d, required 1", level);
         end
      end
      s_valid = 1'b0;
      tick();
      n_checks++;
      if (xfer_cnt !== 8'd8 || level !== 3'd0 || m_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL stream_end: got cnt=%0d lvl=%0d vld=%b, required 8 0 0", xfer_cnt, level, m_valid);
      end
   endtask

   task automatic test_fill();
      logic [7:0] d;
      logic       acc;
      int         acc_n;
      d = 8'h10; acc_n = 0;
      m_ready = 1'b0; s_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         s_data = d;
         acc = s_ready;
         tick();
         if (acc) begin
            d++;
            acc_n++;
            if (acc_n == 4) begin
               n_checks++;
               if (s_ready !== 1'b0 || level !== 3'd4) begin
                  n_errors++;
                  $display("FAIL fill_full: got rdy=%b lvl=%0d, required 0 4", s_ready, level);
               end
            end
         end
      end
      s_data = d;
      n_checks++;
      if (acc_n != 4 || m_data !== 8'h10 || level !== 3'd4) begin
         n_errors++;
         $display("FAIL fill_count: got accepted=%0d lvl=%0d head=%h, required 4 4 10", acc_n, level, m_data);
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      n_checks++;
      if (s_ready !== 1'b1 || level !== 3'd3 || m_data !== 8'h11) begin
         n_errors++;
         $display("FAIL fill_pop: got rdy=%b lvl=%0d head=%h, required 1 3 11", s_ready, level, m_data);
      end
      tick();
      n_checks++;
      if (level !== 3'd4 || s_ready !== 1'b0 || proto_err !== 1'b0) begin
         n_errors++;
         $display("FAIL fill_refill: got lvl=%0d rdy=%b err=%b, required 4 0 0", level, s_ready, proto_err);
      end
      s_valid = 1'b0; m_ready = 1'b1;
      repeat (4) tick();
      n_checks++;
      if (level !== 3'd0 || m_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL fill_drain: got lvl=%0d vld=%b, required 0 0", level, m_valid);
      end
   endtask

   task automatic test_simultaneous();
      m_ready = 1'b0; s_valid = 1'b1;
      s_data = 8'h20; tick();
      s_data = 8'h21; tick();
      n_checks++;
      if (level !== 3'd2) begin
         n_errors++;
         $display("FAIL simul_prefill: got lvl=%0d, required 2", level);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s_data = 8'h22 + 8'(i);
         tick();
         n_checks++;
         if (level !== 3'd2) begin
            n_errors++;
            $display("FAIL simul_level: got lvl=%0d, required 2", level);
         end
      end
      s_valid = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (level !== 3'd0) begin
         n_errors++;
         $display("FAIL simul_drain: got lvl=%0d, required 0", level);
      end
   endtask

   task automatic test_proto();
      logic [7:0] d;
      logic       acc;
      m_ready = 1'b0; s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_data = 8'h30 + 8'(i);
         tick();
      end
      s_data = 8'h55;
      tick();
      n_checks++;
      if (s_ready !== 1'b0 || proto_err !== 1'b0) begin
         n_errors++;
         $display("FAIL proto_pre: got rdy=%b err=%b, required 0 0", s_ready, proto_err);
      end
      s_data = 8'h56;
      tick();
      n_checks++;
      if (proto_err !== 1'b1) begin
         n_errors++;
         $display("FAIL proto_data_change: got err=%b, required 1", proto_err);
      end
      m_ready = 1'b1; d = 8'h56;
      for (int c = 0; c < 6; c++) begin
         acc = s_ready;
         tick();
         if (acc) begin
            d++;
            s_data = d;
         end
         n_checks++;
         if (proto_err !== 1'b1) begin
            n_errors++;
            $display("FAIL proto_sticky_flow: got err=%b, required 1", proto_err);
         end
      end
      s_valid = 1'b0;
      repeat (8) tick();
      n_checks++;
      if (level !== 3'd0 || proto_err !== 1'b1) begin
         n_errors++;
         $display("FAIL proto_drain: got lvl=%0d err=%b, required 0 1", level, proto_err);
      end
      sys_rst = 1'b1; tick(); sys_rst = 1'b0;
      n_checks++;
      if (proto_err !== 1'b0) begin
         n_errors++;
         $display("FAIL proto_clear1: got err=%b, required 0", proto_err);
      end
      m_ready = 1'b0; s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_data = 8'h40 + 8'(i);
         tick();
      end
      s_data = 8'h44;
      tick();
      s_valid = 1'b0;
      tick();
      n_checks++;
      if (proto_err !== 1'b1) begin
         n_errors++;
         $display("FAIL proto_valid_drop: got err=%b, required 1", proto_err);
      end
      repeat (2) tick();
      n_checks++;
      if (proto_err !== 1'b1) begin
         n_errors++;
         $display("FAIL proto_hold: got err=%b, required 1", proto_err);
      end
      sys_rst = 1'b1; tick(); sys_rst = 1'b0;
      n_checks++;
      if (proto_err !== 1'b0 || level !== 3'd0) begin
         n_errors++;
         $display("FAIL proto_clear2: got err=%b lvl=%0d, required 0 0", proto_err, level);
      end
   endtask

   task automatic test_cnt_wrap();
      int   exp_cnt;
      logic pop_now;
      exp_cnt = 0;
      m_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         s_valid = (k < 9);
         s_data  = 8'h60 + 8'(k);
         pop_now = m_valid & m_ready;
         tick();
         if (pop_now) begin
            exp_cnt++;
            n_checks++;
            if (xfer_cnt3 !== exp_cnt[2:0]) begin
               n_errors++;
               $display("FAIL cnt_wrap_step: got %0d, required %0d", xfer_cnt3, exp_cnt[2:0]);
            end
         end
      end
      n_checks++;
      if (exp_cnt != 9 || xfer_cnt3 !== 3'd1 || xfer_cnt !== 8'd9) begin
         n_errors++;
         $display("FAIL cnt_wrap_final: got pops=%0d cnt3=%0d cnt8=%0d, required 9 1 9",
                  exp_cnt, xfer_cnt3, xfer_cnt);
      end
      m_ready = 1'b0; s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = 8'h70 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      n_checks++;
      if (level !== 3'd3) begin
         n_errors++;
         $display("FAIL midrst_pre: got lvl=%0d, required 3", level);
      end
      sys_rst = 1'b1; tick(); sys_rst = 1'b0;
      n_checks++;
      if (level !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL midrst_state: got lvl=%0d vld=%b rdy=%b, required 0 0 1", level, m_valid, s_ready);
      end
      m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h80;
      tick();
      s_valid = 1'b0;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h80) begin
         n_errors++;
         $display("FAIL midrst_fresh: got vld=%b data=%h, required 1 80", m_valid, m_data);
      end
      tick();
      n_checks++;
      if (level !== 3'd0 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL midrst_end: got lvl=%0d pending=%0d, required 0 0", level, exp_q.size());
      end
   endtask

   initial begin
      sys_rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
      test_reset();
      test_streaming();
      test_fill();
      test_simultaneous();
      test_proto();
      test_cnt_wrap();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
